lpc_frame_reader: RTL and testbench

//  Streams one frame of 16-bit speech samples out of the dual-port sample RAM
//  (2048x16, port 2) into the LPC analysis pipeline over a valid/ready stream.

---
 rtl/lpc_frame_reader_pkg.sv | 19 +
 rtl/lpc_frame_reader_if.sv | 35 +++
 rtl/lpc_frame_reader_skid_fifo.sv | 38 +++
 rtl/lpc_frame_reader.sv | 123 ++++++++++++
 tb/tb_lpc_frame_reader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_frame_reader_pkg.sv
// rtl/lpc_frame_reader_pkg.sv - shared widths, length clamp and reader state encoding
package lpc_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 12;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } reader_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction
endpackage

// File: rtl/lpc_frame_reader_if.sv
// rtl/lpc_frame_reader_if.sv - control, sample-RAM port 2 and sample stream bundle
interface lpc_frame_reader_if;
    import lpc_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  frame_len;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;

    modport master (
        input  start, base_addr, frame_len, mem_readdata, src_ready,
        output busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               mem_byteenable, src_data, src_valid, src_sop, src_eop
    );

    modport slave (
        output start, base_addr, frame_len, mem_readdata, src_ready,
        input  busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               mem_byteenable, src_data, src_valid, src_sop, src_eop
    );
endinterface

// File: rtl/lpc_frame_reader_skid_fifo.sv
// rtl/lpc_frame_reader_skid_fifo.sv - two-entry landing buffer for RAM read data
module lpc_skid_fifo #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // The reader's credit scheme guarantees no push when full and no pop when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/lpc_frame_reader.sv
// rtl/lpc_frame_reader.sv - streams one frame of samples from RAM port 2 to the LPC pipeline
module lpc_frame_reader
    import lpc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    lpc_frame_reader_if.master  bus
);
    reader_state_t     state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  out_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_pending;
    logic              rd_sop;
    logic              rd_eop;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        fifo_count;
    logic [DATA_W+1:0] fifo_head;
    logic [LEN_W-1:0]  start_len;
    logic              issue;
    logic              pop;
    logic              last_issue;
    logic              last_pop;

    assign start_len  = clamp_len(bus.frame_len);
    assign pop        = bus.src_valid && bus.src_ready;
    assign last_issue = (issue_cnt == len_q - LEN_W'(1));
    assign last_pop   = (out_cnt == len_q - LEN_W'(1));

    // The beat leaving this cycle frees its slot, which keeps one read per clock with ready high.
    always_comb begin
        issue = 1'b0;
        if (state == ST_READ) begin
            issue = ({2'b00, rd_pending} + {1'b0, fifo_count}) < (3'd2 + {2'b00, pop});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            issue_cnt  <= '0;
            out_cnt    <= '0;
            addr_q     <= '0;
            rd_pending <= 1'b0;
            rd_sop     <= 1'b0;
            rd_eop     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_pending <= issue;
            rd_sop     <= issue && (issue_cnt == '0);
            rd_eop     <= issue && last_issue;
            if (issue) begin
                addr_q    <= addr_q + ADDR_W'(1);
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (pop) begin
                out_cnt <= out_cnt + LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q     <= start_len;
                        addr_q    <= bus.base_addr;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        if (start_len == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue && last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && last_pop) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    lpc_skid_fifo #(.WIDTH(DATA_W + 2)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pending),
        .push_data ({rd_sop, rd_eop, bus.mem_readdata}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_clken      = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 2'b11;
    assign bus.src_valid      = (fifo_count != 2'd0);
    assign bus.src_data       = fifo_head[DATA_W-1:0];
    assign bus.src_sop        = bus.src_valid && fifo_head[DATA_W+1];
    assign bus.src_eop        = bus.src_valid && fifo_head[DATA_W];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_lpc_frame_reader.sv
// tb/tb_lpc_frame_reader.sv - scoreboard bench for lpc_frame_reader
module tb_lpc_frame_reader;
    import lpc_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lpc_frame_reader_if bus();

    lpc_frame_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t       exp_q[$];
    logic [10:0] addr_exp_q[$];
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int done_count = 0;
    int exp_done_cyc = -1;
    int first_hs_cyc = 0;
    int last_hs_cyc = 0;
    int occ_m = 0;
    int infl_m = 0;
    bit prev_stall = 1'b0;
    beat_t prev_beat;
    bit ready_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port 2 model: registered q_b, ram[a] = a ^ 16'h5A5A
    initial bus.mem_readdata = '0;
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken)
            bus.mem_readdata <= 16'(bus.mem_address) ^ 16'h5A5A;
    end

    always @(posedge clk) begin
        #1 bus.src_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every handshake
    always @(negedge clk) begin
        beat_t e;
        beat_t cur;
        int    pop;
        if (reset) begin
            occ_m = 0;
            infl_m = 0;
            prev_stall = 1'b0;
        end else begin
            pop = (bus.src_valid && bus.src_ready) ? 1 : 0;
            cur = '{data: bus.src_data, sop: bus.src_sop, eop: bus.src_eop};
            if (bus.mem_clken) begin
                check("credit_limit", 32'(infl_m + occ_m - pop <= 1), 32'd1);
                check("cs_with_clken", 32'(bus.mem_chipselect), 32'd1);
                if (addr_exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_read: got addr %0d expected none", bus.mem_address);
                end else begin
                    check("read_addr", 32'(bus.mem_address), 32'(addr_exp_q.pop_front()));
                end
            end
            if (prev_stall) begin
                check("stall_valid_held", 32'(bus.src_valid), 32'd1);
                check("stall_beat_held", 32'(cur), 32'(prev_beat));
            end
            if (pop != 0) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_beat: got data %0h expected none", bus.src_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(cur.data), 32'(e.data));
                    check("beat_sop", 32'(cur.sop), 32'(e.sop));
                    check("beat_eop", 32'(cur.eop), 32'(e.eop));
                end
                beats++;
                last_hs_cyc = cyc;
                if (cur.sop) first_hs_cyc = cyc;
                if (cur.eop) exp_done_cyc = cyc + 1;
            end
            if (bus.done) begin
                done_count++;
                check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                check("busy_low_with_done", 32'(bus.busy), 32'd0);
                exp_done_cyc = -1;
            end
            prev_stall = bus.src_valid && !bus.src_ready;
            prev_beat = cur;
            occ_m = occ_m + infl_m - pop;
            infl_m = bus.mem_clken ? 1 : 0;
        end
    end

    task automatic run_frame(input int base, input int len, input bit rnd,
                             input bit chk_gap, input bit inject);
        int n;
        int d0;
        n = (len > 2048) ? 2048 : len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{data: 16'((base + i) % 2048) ^ 16'h5A5A,
                              sop: (i == 0), eop: (i == n - 1)});
            addr_exp_q.push_back(11'((base + i) % 2048));
        end
        ready_rand = rnd;
        d0 = done_count;
        @(posedge clk); #1;
        bus.base_addr = 11'(base);
        bus.frame_len = 12'(len);
        bus.start = 1'b1;
        if (n == 0) exp_done_cyc = cyc + 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'(n != 0));
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            bus.base_addr = 11'd5;
            bus.frame_len = 12'd3;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        for (int k = 0; k < 4 * n + 40 && done_count == d0; k++) @(posedge clk);
        #1;
        check("done_seen", 32'(done_count != d0), 32'd1);
        check("all_beats_out", 32'(exp_q.size()), 32'd0);
        check("all_reads_issued", 32'(addr_exp_q.size()), 32'd0);
        if (chk_gap && n > 0) check("no_gaps", 32'(last_hs_cyc - first_hs_cyc), 32'(n - 1));
        exp_q.delete();
        addr_exp_q.delete();
        ready_rand = 1'b0;
    endtask

    initial begin
        int b0;
        int dc0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.frame_len = '0;
        bus.src_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.src_valid), 32'd0);
        check("rst_sop_eop", 32'({bus.src_sop, bus.src_eop}), 32'd0);
        check("rst_cs_clken", 32'({bus.mem_chipselect, bus.mem_clken}), 32'd0);
        check("rst_address", 32'(bus.mem_address), 32'd0);
        check("rst_data", 32'(bus.src_data), 32'd0);
        check("mem_write_tied", 32'(bus.mem_write), 32'd0);
        check("byteenable_tied", 32'(bus.mem_byteenable), 32'd3);
        reset = 1'b0;

        run_frame(0, 8, 1'b0, 1'b1, 1'b0);
        run_frame(2044, 8, 1'b0, 1'b1, 1'b0);
        run_frame(7, 16, 1'b1, 1'b0, 1'b0);
        run_frame(500, 1, 1'b0, 1'b1, 1'b0);
        run_frame(20, 0, 1'b0, 1'b0, 1'b0);
        run_frame(300, 8, 1'b1, 1'b0, 1'b1);
        run_frame(1000, 4095, 1'b0, 1'b1, 1'b0);

        // Abort a len=10 frame after three beats
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back('{data: 16'(40 + i) ^ 16'h5A5A, sop: (i == 0), eop: (i == 9)});
            addr_exp_q.push_back(11'(40 + i));
        end
        b0 = beats;
        dc0 = done_count;
        @(posedge clk); #1;
        bus.base_addr = 11'd40;
        bus.frame_len = 12'd10;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 60 && beats < b0 + 3; k++) @(negedge clk);
        check("abort_reached_3_beats", 32'(beats - b0), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.src_valid), 32'd0);
        check("abort_clken", 32'(bus.mem_clken), 32'd0);
        check("abort_data", 32'(bus.src_data), 32'd0);
        check("abort_address", 32'(bus.mem_address), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        addr_exp_q.delete();
        exp_done_cyc = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done_count), 32'(dc0));

        run_frame(100, 2, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
